// File: rtl/rob_wb_arbiter_if.sv
// Write-back bus between the execution units, the arbiter and the ROB result port.
// Requester i occupies slice i of every packed req_* bus.
interface rob_wb_arbiter_if #(
   parameter int ROB_WIDTH = 4,
   parameter int N_REQ     = 3
);
   logic [N_REQ-1:0]           req_valid;
   logic [N_REQ-1:0]           req_ready;
   logic [N_REQ*ROB_WIDTH-1:0] req_tag;
   logic [N_REQ*3-1:0]         req_op;
   logic [N_REQ*5-1:0]         req_rd;
   logic [N_REQ*32-1:0]        req_wdata;
   logic [N_REQ*32-1:0]        req_jump;
   logic                       to_rob;
   logic [ROB_WIDTH-1:0]       to_rob_tag;
   logic [2:0]                 to_rob_op;
   logic [4:0]                 to_rob_rd;
   logic [31:0]                to_rob_wdata;
   logic [31:0]                to_rob_jump;

   modport master (
      output req_valid, req_tag, req_op, req_rd, req_wdata, req_jump,
      input  req_ready, to_rob, to_rob_tag, to_rob_op, to_rob_rd, to_rob_wdata, to_rob_jump
   );

   modport slave (
      input  req_valid, req_tag, req_op, req_rd, req_wdata, req_jump,
      output req_ready, to_rob, to_rob_tag, to_rob_op, to_rob_rd, to_rob_wdata, to_rob_jump
   );
endinterface

// File: rtl/rob_wb_arbiter.sv
// ROB write-back arbiter: one holding slot per execution unit, one registered result per cycle.
// Define WBARB_FIXED_PRIO_EN for lowest-index-wins priority instead of round-robin.
module rob_wb_arbiter #(
   parameter int ROB_WIDTH = 4,
   parameter int N_REQ     = 3
) (
   input  logic            clk_in,
   input  logic            rst_n_in,
   input  logic            rdy_in,
   input  logic            clear_in,
   rob_wb_arbiter_if.slave bus
);
   localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

   logic [N_REQ-1:0]     full_r;
   logic [ROB_WIDTH-1:0] tag_r   [N_REQ];
   logic [2:0]           op_r    [N_REQ];
   logic [4:0]           rd_r    [N_REQ];
   logic [31:0]          wdata_r [N_REQ];
   logic [31:0]          jump_r  [N_REQ];

   logic [N_REQ-1:0]     pick_s;
   logic [N_REQ-1:0]     grant_s;
   logic [N_REQ-1:0]     ready_s;
   logic [N_REQ-1:0]     accept_s;
   logic [PTR_W-1:0]     win_idx_s;
   logic [ROB_WIDTH-1:0] win_tag_s;
   logic [2:0]           win_op_s;
   logic [4:0]           win_rd_s;
   logic [31:0]          win_wdata_s;
   logic [31:0]          win_jump_s;

   logic                 to_rob_r;
   logic [ROB_WIDTH-1:0] out_tag_r;
   logic [2:0]           out_op_r;
   logic [4:0]           out_rd_r;
   logic [31:0]          out_wdata_r;
   logic [31:0]          out_jump_r;

`ifdef WBARB_FIXED_PRIO_EN
   // Candidate set: every full slot, so the lowest index wins.
   always_comb begin
      pick_s = full_r;
   end
`else
   logic [PTR_W-1:0] ptr_r;
   logic [N_REQ-1:0] hi_mask_s;

   // Candidate set: full slots at or above ptr first, otherwise wrap to all full slots.
   always_comb begin
      hi_mask_s = '0;
      for (int i = 0; i < N_REQ; i++) begin
         hi_mask_s[i] = (PTR_W'(i) >= ptr_r);
      end
      if (|(full_r & hi_mask_s)) begin
         pick_s = full_r & hi_mask_s;
      end else begin
         pick_s = full_r;
      end
   end

   // Round-robin pointer: moves past the winner, holds on no grant, clear or stall.
   always_ff @(posedge clk_in) begin
      if (!rst_n_in) begin
         ptr_r <= '0;
      end else if (rdy_in && !clear_in && (|grant_s)) begin
         ptr_r <= (win_idx_s == PTR_W'(N_REQ - 1)) ? '0 : win_idx_s + PTR_W'(1);
      end else begin
         ptr_r <= ptr_r;
      end
   end
`endif

   // Grant isolates the lowest candidate bit; depends only on registered state.
   always_comb begin
      grant_s = pick_s & (~pick_s + N_REQ'(1));
   end

   // One-hot OR-mux of the winning slot.
   always_comb begin
      win_idx_s   = '0;
      win_tag_s   = '0;
      win_op_s    = 3'b000;
      win_rd_s    = 5'd0;
      win_wdata_s = 32'd0;
      win_jump_s  = 32'd0;
      for (int i = 0; i < N_REQ; i++) begin
         if (grant_s[i]) begin
            win_idx_s   = win_idx_s | PTR_W'(i);
            win_tag_s   = win_tag_s | tag_r[i];
            win_op_s    = win_op_s | op_r[i];
            win_rd_s    = win_rd_s | rd_r[i];
            win_wdata_s = win_wdata_s | wdata_r[i];
            win_jump_s  = win_jump_s | jump_r[i];
         end else begin
            win_idx_s   = win_idx_s;
         end
      end
   end

   // Ready: empty slots, or the slot being drained this cycle, may accept.
   always_comb begin
      if (rst_n_in && rdy_in && !clear_in) begin
         ready_s = ~full_r | grant_s;
      end else begin
         ready_s = '0;
      end
      accept_s = bus.req_valid & ready_s;
   end

   // Holding slots: refill wins over drain so a lone unit streams one per cycle.
   always_ff @(posedge clk_in) begin
      if (!rst_n_in) begin
         full_r <= '0;
         for (int i = 0; i < N_REQ; i++) begin
            tag_r[i]   <= '0;
            op_r[i]    <= 3'b100;
            rd_r[i]    <= 5'd0;
            wdata_r[i] <= 32'd0;
            jump_r[i]  <= 32'd0;
         end
      end else if (rdy_in && clear_in) begin
         full_r <= '0;
      end else if (rdy_in) begin
         for (int i = 0; i < N_REQ; i++) begin
            if (accept_s[i]) begin
               full_r[i]  <= 1'b1;
               tag_r[i]   <= bus.req_tag[i*ROB_WIDTH +: ROB_WIDTH];
               op_r[i]    <= bus.req_op[i*3 +: 3];
               rd_r[i]    <= bus.req_rd[i*5 +: 5];
               wdata_r[i] <= bus.req_wdata[i*32 +: 32];
               jump_r[i]  <= bus.req_jump[i*32 +: 32];
            end else if (grant_s[i]) begin
               full_r[i]  <= 1'b0;
            end
         end
      end
   end

   // Output register: one-cycle strobe per grant, data holds between grants.
   always_ff @(posedge clk_in) begin
      if (!rst_n_in) begin
         to_rob_r    <= 1'b0;
         out_tag_r   <= '0;
         out_op_r    <= 3'b100;
         out_rd_r    <= 5'd0;
         out_wdata_r <= 32'd0;
         out_jump_r  <= 32'd0;
      end else if (rdy_in) begin
         if (clear_in) begin
            to_rob_r <= 1'b0;
         end else if (|grant_s) begin
            to_rob_r    <= 1'b1;
            out_tag_r   <= win_tag_s;
            out_op_r    <= win_op_s;
            out_rd_r    <= win_rd_s;
            out_wdata_r <= win_wdata_s;
            out_jump_r  <= win_jump_s;
         end else begin
            to_rob_r <= 1'b0;
         end
      end
   end

   assign bus.req_ready    = ready_s;
   assign bus.to_rob       = to_rob_r;
   assign bus.to_rob_tag   = out_tag_r;
   assign bus.to_rob_op    = out_op_r;
   assign bus.to_rob_rd    = out_rd_r;
   assign bus.to_rob_wdata = out_wdata_r;
   assign bus.to_rob_jump  = out_jump_r;
endmodule
